// File: rtl/mcoc_fetch_pkg.sv
// Shared fetch-unit constants and the queue entry type.
// Used by the fetch top level and its halfword queue.
package mcoc_fetch_pkg;

  localparam logic [1:0] FCMD_IDLE = 2'b00;
  localparam logic [1:0] FCMD_RD16 = 2'b01;
  localparam logic [1:0] FCMD_RD32 = 2'b11;

  typedef struct packed {
    logic [15:0] hw;
    logic [15:0] adr;
  } fetch_ent_t;

endpackage

// File: rtl/mcoc_fetch_q.sv
// Halfword+address queue: up to two writes and one pop per cycle.
// Slot wr0 is always the lower-address halfword and is written first.
module mcoc_fetch_q
  import mcoc_fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [1:0]                 wr_n,
  input  fetch_ent_t                 wr0,
  input  fetch_ent_t                 wr1,
  input  logic                       pop,
  output fetch_ent_t                 head,
  output logic [$clog2(QDEPTH):0]    cnt
);

  localparam int AW = $clog2(QDEPTH);

  fetch_ent_t       mem [QDEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok;

  assign pop_ok = pop && (cnt != '0);
  assign head   = mem[rd_ptr];

  // Storage needs no reset: pointers and count decide what is visible.
  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) mem[wr_ptr] <= wr0;
    if (wr_n == 2'd2) mem[wr_ptr + AW'(1)] <= wr1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_n);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(wr_n) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/mcoc_fetch.sv
// Instruction fetch front end: issues 16/32-bit reads, tracks the one
// in-flight response and feeds a halfword queue; jmp redirects the stream.
module mcoc_fetch
  import mcoc_fetch_pkg::*;
#(
  parameter logic [15:0] RST_VEC = 16'h0000,
  parameter int          QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [1:0]  fcmd,
  output logic [15:0] fadr,
  input  logic [31:0] fdat,
  input  logic        jmp,
  input  logic [15:0] jadr,
  output logic [15:0] ir,
  output logic [15:0] ipc,
  output logic        ir_vld,
  input  logic        ir_ack
);

  localparam int CW = $clog2(QDEPTH) + 1;

  logic [15:0]   fptr;
  logic [1:0]    pend_n;
  logic [15:0]   pend_adr;
  logic [CW-1:0] q_cnt;
  logic [CW:0]   occ;
  logic          pop;
  logic [1:0]    fcmd_c;
  logic [1:0]    wr_n;
  fetch_ent_t    wr0;
  fetch_ent_t    wr1;
  fetch_ent_t    head;

  // Consumer handshake: the head halfword transfers in any cycle where
  // ir_vld and ir_ack are both high; ir_ack alone is ignored.
  assign ir_vld = !rst && (q_cnt != '0);
  assign pop    = ir_vld && ir_ack;
  assign ir     = ir_vld ? head.hw  : 16'h0000;
  assign ipc    = ir_vld ? head.adr : 16'h0000;

  // Occupancy the queue would reach if everything in flight lands now.
  assign occ = (CW+1)'(q_cnt) + (CW+1)'(pend_n) - (CW+1)'(pop);

  always_comb begin
    fcmd_c = FCMD_IDLE;
    if (!rst && !jmp) begin
      if (!fptr[1] && occ <= (CW+1)'(QDEPTH - 2))
        fcmd_c = FCMD_RD32;
      else if (occ <= (CW+1)'(QDEPTH - 1))
        fcmd_c = FCMD_RD16;
    end
  end

  assign fcmd = fcmd_c;
  assign fadr = rst ? RST_VEC : fptr;

  // The response is only enqueued when neither rst nor jmp is active,
  // because the queue clear wins over the write in the same cycle.
  always_comb begin
    wr_n = 2'd0;
    wr0  = '0;
    wr1  = '0;
    if (pend_n == 2'd2) begin
      wr_n = 2'd2;
      wr0  = fetch_ent_t'{hw: fdat[31:16], adr: pend_adr};
      wr1  = fetch_ent_t'{hw: fdat[15:0],  adr: pend_adr + 16'd2};
    end else if (pend_n == 2'd1) begin
      wr_n = 2'd1;
      wr0  = fetch_ent_t'{hw: fdat[15:0],  adr: pend_adr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fptr     <= RST_VEC;
      pend_n   <= 2'd0;
      pend_adr <= RST_VEC;
    end else if (jmp) begin
      fptr     <= jadr & 16'hFFFE;
      pend_n   <= 2'd0;
      pend_adr <= fptr;
    end else begin
      pend_adr <= fptr;
      case (fcmd_c)
        FCMD_RD32: begin
          fptr   <= fptr + 16'd4;
          pend_n <= 2'd2;
        end
        FCMD_RD16: begin
          fptr   <= fptr + 16'd2;
          pend_n <= 2'd1;
        end
        default: pend_n <= 2'd0;
      endcase
    end
  end

  mcoc_fetch_q #(.QDEPTH(QDEPTH)) u_q (
    .clk  (clk),
    .rst  (rst),
    .clr  (jmp),
    .wr_n (wr_n),
    .wr0  (wr0),
    .wr1  (wr1),
    .pop  (pop),
    .head (head),
    .cnt  (q_cnt)
  );

endmodule
